// File: rtl/hazard_control_unit.sv
// Pipeline sequencing: load-use stalls, multi-cycle EX hold,
// memory-wait freeze and branch squash for the 5-stage core.
module hazard_control_unit #(
  parameter int MC_LATENCY = 4,
  parameter bit ZERO_REG_HARDWIRED = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [3:0]       ex_dest,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mc_start,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             mc_done,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MC_BUSY} state_t;

  localparam logic [3:0] MC_INIT = 4'(MC_LATENCY - 2);

  state_t     state, state_n;
  logic [3:0] mc_cnt, mc_cnt_n;
  logic       mem_wait;
  logic       src_hit;
  logic       zero_mask;
  logic       load_use;

  assign mem_wait  = mem_req & ~mem_ready;
  assign src_hit   = (id_uses_rs1 && (id_rs1 == ex_dest)) ||
                     (id_uses_rs2 && (id_rs2 == ex_dest));
  assign zero_mask = ZERO_REG_HARDWIRED && (ex_dest == 4'd0);
  assign load_use  = ex_mem_read & ex_reg_write & src_hit & ~zero_mask;

  always_comb begin
    state_n       = state;
    mc_cnt_n      = mc_cnt;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    mc_done       = 1'b0;
    busy          = (state == MC_BUSY);
    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
      busy          = 1'b0;
    end else if (mem_wait) begin
      // full freeze; the multi-cycle op keeps counting underneath
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      if (mc_cnt != 4'd0) mc_cnt_n = mc_cnt - 4'd1;
    end else if (state == MC_BUSY) begin
      if (mc_cnt != 4'd0) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_bubble = 1'b1;
        mc_cnt_n      = mc_cnt - 4'd1;
      end else begin
        mc_done = 1'b1;
        state_n = RUN;
      end
    end else if (ex_mc_start) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
      state_n       = MC_BUSY;
      mc_cnt_n      = MC_INIT;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      mc_cnt <= 4'd0;
    end else begin
      state  <= state_n;
      mc_cnt <= mc_cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencing controller for the 5-stage 32-bit core (16 registers, 4-bit indices).
- Detects load-use hazards that the EX/WB forwarding muxes cannot cover.
- Sequences a multi-cycle EX operation.
- Freezes the pipeline on memory wait.
- Squashes wrong-path instructions on taken branches.
- Drives the enables and bubble controls of the PC and IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- MC_LATENCY, 4, total cycles a multi-cycle op occupies EX; legal range 2..15.
- ZERO_REG_HARDWIRED, 0, if 1 a source or destination index of 0 never raises a load-use hazard.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs1  in  4  decode-stage source register 1
- id_rs2  in  4  decode-stage source register 2
- id_uses_rs1  in  1  decode instruction reads rs1
- id_uses_rs2  in  1  decode instruction reads rs2
- ex_dest  in  4  EX-stage destination register
- ex_reg_write  in  1  EX instruction writes a register
- ex_mem_read  in  1  EX instruction is a load
- ex_mc_start  in  1  EX instruction is a multi-cycle op; valid only in RUN
- ex_branch_taken  in  1  EX resolved a taken branch
- mem_req  in  1  MEM stage is issuing a memory access
- mem_ready  in  1  memory completes the access this cycle
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register enable
- id_ex_en  out  1  ID/EX register enable
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_en  out  1  MEM/WB register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_mem_bubble  out  1  load NOP into EX/MEM
- mem_wb_bubble  out  1  load NOP into MEM/WB
- mc_done  out  1  one-cycle pulse when a multi-cycle op releases EX
- busy  out  1  state is MC_BUSY
- stall_cycles  out  CNT_W  count of cycles with pc_en=0; saturating

Behaviour:
- Registered state: one bit, RUN or MC_BUSY. Counter mc_cnt is 4 bits. stall_cycles is CNT_W bits.
- Reset: state=RUN, mc_cnt=0, stall_cycles=0.
- While rst=1, all outputs are forced combinationally:
  - all *_en = 0;
  - all flush/bubble signals = 1;
  - mc_done = 0, busy = 0.
- After reset, all controls are combinational from state, mc_cnt and inputs (zero added latency). The default is all enables 1 and all flush/bubble signals 0.
- Evaluation priority, highest first:
  1. Memory wait: mem_req=1 and mem_ready=0.
     - pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en = 0.
     - mem_wb_bubble = 1.
     - No flush or bubble is raised elsewhere; ex_branch_taken and load-use are ignored this cycle.
     - mc_cnt still decrements, but does not go below 0.
  2. MC_BUSY:
     - If mc_cnt != 0: pc_en, if_id_en, id_ex_en = 0; ex_mem_bubble = 1; mc_cnt decrements.
     - If mc_cnt == 0: defaults apply, mc_done = 1, next state = RUN.
     - If memory wait coincides with mc_cnt == 0, release and mc_done are deferred until memory wait clears.
  3. RUN with ex_mc_start=1:
     - Same stall outputs as MC_BUSY with mc_cnt != 0.
     - Next state = MC_BUSY, mc_cnt <= MC_LATENCY-2.
     - Result: MC_LATENCY-1 stall cycles; EX is occupied for MC_LATENCY cycles.
  4. RUN with ex_branch_taken=1:
     - if_id_flush = 1, id_ex_bubble = 1; pc_en = 1 so the target loads.
     - Load-use is suppressed because the ID instruction is squashed.
  5. RUN with load-use hazard:
     - Hazard condition: ex_mem_read & ex_reg_write & ((id_uses_rs1 & id_rs1==ex_dest) | (id_uses_rs2 & id_rs2==ex_dest)).
     - With ZERO_REG_HARDWIRED=1, the hazard is masked when ex_dest==0.
     - Response: pc_en = 0, if_id_en = 0, id_ex_bubble = 1, for exactly one cycle. The next cycle the load is in MEM and forwarding covers it.
- stall_cycles increments on each clock edge where rst=0 and pc_en=0. It holds at all-ones.
- ex_mc_start while in MC_BUSY is ignored.
- Asserting rst mid-MC_BUSY aborts to RUN immediately, with no mc_done pulse.

Test Plan:
- Reset → all enables 0, all bubbles 1, stall_cycles=0. First cycle after release: all enables 1, state RUN.
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_dest=5, id_rs2=5, id_uses_rs2=1 → for one cycle pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cycles=1; next cycle defaults. Repeat with ZERO_REG_HARDWIRED=1, ex_dest=0, id_rs1=0 → no stall.
- MC_LATENCY=4, ex_mc_start pulsed at cycle t → pc_en=0 and ex_mem_bubble=1 at t, t+1, t+2; mc_done=1 and pc_en=1 at t+3; busy=1 at t+1..t+3; stall_cycles += 3.
- ex_branch_taken with a simultaneous load-use match → if_id_flush=1, id_ex_bubble=1, pc_en=1; no stall counted.
- mem_req=1, mem_ready=0 for 3 cycles during an MC op whose mc_cnt reaches 0 → all enables 0, mem_wb_bubble=1; mc_done asserts only in the cycle mem_ready=1.
- rst asserted at t+1 of an MC op → state RUN, no mc_done. stall_cycles driven to 0xFFFF with a constant stall → holds at 0xFFFF.
